hex_segment_decoder: RTL and testbench

//  Inverse of the hex-to-7-segment encoder. Monitors NUM_DIGITS active-low seven-segment buses and

---
 rtl/hex_segment_decoder.sv | 259 +++++++++++++++++++++++++
 tb/tb_hex_segment_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_segment_decoder.sv
// hex_segment_decoder: debounces NUM_DIGITS active-low 7-segment buses, decodes them back to hex
// and reports each committed change as a valid/ready event. Define HEXDEC_ERRCNT_EN for err_count.
module hex_segment_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [7*NUM_DIGITS-1:0] HEX_in,
   output logic [4*NUM_DIGITS-1:0] val_out,
   output logic [NUM_DIGITS-1:0]   digit_ok,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [2:0]              evt_digit,
   output logic [3:0]              evt_val,
   output logic                    evt_err
`ifdef HEXDEC_ERRCNT_EN
   ,
   output logic [7:0]              err_count
`endif
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESENT = 1'b1;

   // Returns {legal, value}; any pattern outside the table is illegal.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'h40:   seg_decode = {1'b1, 4'h0};
         7'h79:   seg_decode = {1'b1, 4'h1};
         7'h24:   seg_decode = {1'b1, 4'h2};
         7'h30:   seg_decode = {1'b1, 4'h3};
         7'h19:   seg_decode = {1'b1, 4'h4};
         7'h12:   seg_decode = {1'b1, 4'h5};
         7'h02:   seg_decode = {1'b1, 4'h6};
         7'h78:   seg_decode = {1'b1, 4'h7};
         7'h00:   seg_decode = {1'b1, 4'h8};
         7'h10:   seg_decode = {1'b1, 4'h9};
         7'h08:   seg_decode = {1'b1, 4'hA};
         7'h03:   seg_decode = {1'b1, 4'hB};
         7'h46:   seg_decode = {1'b1, 4'hC};
         7'h21:   seg_decode = {1'b1, 4'hD};
         7'h06:   seg_decode = {1'b1, 4'hE};
         7'h0E:   seg_decode = {1'b1, 4'hF};
         default: seg_decode = 5'h00;
      endcase
   endfunction

   logic [6:0]              hex_q [NUM_DIGITS];
   logic [6:0]              com_q [NUM_DIGITS];
   logic [6:0]              com_d [NUM_DIGITS];
   logic [CW-1:0]           cnt_q [NUM_DIGITS];
   logic [CW-1:0]           cnt_d [NUM_DIGITS];
   logic [4:0]              dec_s [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   commit_s;
   logic [NUM_DIGITS-1:0]   clr_s;
   logic [NUM_DIGITS-1:0]   pending_q, pending_d;
   logic [NUM_DIGITS-1:0]   ok_q, ok_d;
   logic [4*NUM_DIGITS-1:0] val_q, val_d;
   logic [0:0]              state_q, state_d;
   logic [2:0]              ptr_q, ptr_d;
   logic [2:0]              evt_digit_q, evt_digit_d;
   logic [3:0]              evt_val_q, evt_val_d;
   logic                    evt_valid_q, evt_valid_d;
   logic                    evt_err_q, evt_err_d;
   logic                    found_s;
   logic                    take_s;
   logic [2:0]              sel_s;
   logic [3:0]              sel_val_s;
   logic                    sel_ok_s;

   // Per-digit debounce counter, commit detection and decoded result update
   always_comb begin
      commit_s = '0;
      val_d    = val_q;
      ok_d     = ok_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dec_s[i] = seg_decode(hex_q[i]);
         com_d[i] = com_q[i];
         cnt_d[i] = '0;
         if (HEX_in[7*i +: 7] == hex_q[i]) begin
            if (cnt_q[i] != CNT_MAX) begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
               cnt_d[i] = cnt_q[i];
            end
            if ((cnt_q[i] == CNT_LAST) && (hex_q[i] != com_q[i])) begin
               commit_s[i] = 1'b1;
            end else begin
               commit_s[i] = 1'b0;
            end
         end else begin
            cnt_d[i] = '0;
         end
         if (commit_s[i]) begin
            com_d[i] = hex_q[i];
            if (dec_s[i][4]) begin
               val_d[4*i +: 4] = dec_s[i][3:0];
               ok_d[i]         = 1'b1;
            end else begin
               ok_d[i]         = 1'b0;
            end
         end else begin
            com_d[i] = com_q[i];
         end
      end
   end

   // Round-robin pick: lowest pending index >= ptr, otherwise lowest pending index overall
   always_comb begin
      found_s   = |pending_q;
      sel_s     = 3'd0;
      sel_val_s = 4'd0;
      sel_ok_s  = 1'b0;
      clr_s     = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_s     = 3'(i);
            sel_val_s = val_d[4*i +: 4];
            sel_ok_s  = ok_d[i];
            clr_s     = '0;
            clr_s[i]  = 1'b1;
         end else begin
            sel_s     = sel_s;
         end
      end
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (pending_q[i] && (3'(i) >= ptr_q)) begin
            sel_s     = 3'(i);
            sel_val_s = val_d[4*i +: 4];
            sel_ok_s  = ok_d[i];
            clr_s     = '0;
            clr_s[i]  = 1'b1;
         end else begin
            sel_s     = sel_s;
         end
      end
   end

   // Event FSM; a commit landing on the digit being cleared re-arms it (set wins)
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      evt_valid_d = evt_valid_q;
      evt_digit_d = evt_digit_q;
      evt_val_d   = evt_val_q;
      evt_err_d   = evt_err_q;
      take_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               take_s      = 1'b1;
               evt_digit_d = sel_s;
               evt_val_d   = sel_val_s;
               evt_err_d   = ~sel_ok_s;
               evt_valid_d = 1'b1;
               state_d     = ST_PRESENT;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_PRESENT: begin
            if (evt_valid_q && evt_ready) begin
               evt_valid_d = 1'b0;
               ptr_d       = (evt_digit_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : evt_digit_q + 3'd1;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_PRESENT;
            end
         end
         default: begin
            evt_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      pending_d = (pending_q & ~(take_s ? clr_s : '0)) | commit_s;
   end

   // State registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_q[i] <= 7'h7F;
            com_q[i] <= 7'h7F;
            cnt_q[i] <= '0;
         end
         pending_q   <= '0;
         ok_q        <= '0;
         val_q       <= '0;
         state_q     <= ST_IDLE;
         ptr_q       <= 3'd0;
         evt_valid_q <= 1'b0;
         evt_digit_q <= 3'd0;
         evt_val_q   <= 4'd0;
         evt_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_q[i] <= HEX_in[7*i +: 7];
            com_q[i] <= com_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         pending_q   <= pending_d;
         ok_q        <= ok_d;
         val_q       <= val_d;
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         evt_valid_q <= evt_valid_d;
         evt_digit_q <= evt_digit_d;
         evt_val_q   <= evt_val_d;
         evt_err_q   <= evt_err_d;
      end
   end

   assign val_out   = val_q;
   assign digit_ok  = ok_q;
   assign evt_valid = evt_valid_q;
   assign evt_digit = evt_digit_q;
   assign evt_val   = evt_val_q;
   assign evt_err   = evt_err_q;

`ifdef HEXDEC_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [3:0] ill_s;
   logic [8:0] err_sum_s;

   // Saturating sum of illegal commits across all digits
   always_comb begin
      ill_s = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (commit_s[i] && !dec_s[i][4]) begin
            ill_s = ill_s + 4'd1;
         end else begin
            ill_s = ill_s;
         end
      end
      err_sum_s = {1'b0, err_cnt_q} + {5'd0, ill_s};
      if (err_sum_s > 9'd255) begin
         err_cnt_d = 8'hFF;
      end else begin
         err_cnt_d = err_sum_s[7:0];
      end
   end

   // Error counter register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Scoreboard bench for hex_segment_decoder (NUM_DIGITS=4, STABLE_CYCLES=16).
module tb_hex_segment_decoder;

   localparam int ND = 4;

   logic          Clk       = 1'b0;
   logic          Reset     = 1'b1;
   logic          evt_ready = 1'b0;
   logic [7*ND-1:0] hex_s   = {ND{7'h7F}};
   logic [4*ND-1:0] val_out;
   logic [ND-1:0] digit_ok;
   logic          evt_valid;
   logic [2:0]    evt_digit;
   logic [3:0]    evt_val;
   logic          evt_err;
`ifdef HEXDEC_ERRCNT_EN
   logic [7:0]    err_count;
`endif

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc      = 0;
   logic [7:0]    sb_q [$];
   int            acc_cyc [$];
   logic          valid_seen = 1'b0;
   logic [6:0]    seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   hex_segment_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(16)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .HEX_in    (hex_s),
      .val_out   (val_out),
      .digit_ok  (digit_ok),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_digit (evt_digit),
      .evt_val   (evt_val),
      .evt_err   (evt_err)
`ifdef HEXDEC_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ev(input int d, input int v, input int e);
      return {3'(d), 4'(v), 1'(e)};
   endfunction

   // Scoreboard: compare every accepted event against the oldest expected one
   always @(negedge Clk) begin : mon
      logic [7:0] exp_ev;
      if (evt_valid) valid_seen = 1'b1;
      if (evt_valid && evt_ready) begin
         acc_cyc.push_back(cyc);
         if (sb_q.size() == 0) begin
            chk_eq("sb_unexpected", {24'd0, evt_digit, evt_val, evt_err}, 32'h100);
         end else begin
            exp_ev = sb_q.pop_front();
            chk_eq("sb_event", {24'd0, evt_digit, evt_val, evt_err}, {24'd0, exp_ev});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic set_dig(input int d, input logic [6:0] pat);
      hex_s[7*d +: 7] = pat;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      chk_eq(tag, sb_q.size(), 0);
      tick(2);
   endtask

   initial begin
      int n;
      // 1: reset, blank inputs, nothing happens
      tick(2);
      Reset = 1'b0;
      chk_eq("rst_val_out", val_out, 0);
      chk_eq("rst_digit_ok", digit_ok, 0);
      chk_eq("rst_evt", {evt_valid, evt_digit, evt_val, evt_err}, 0);
`ifdef HEXDEC_ERRCNT_EN
      chk_eq("rst_err_count", err_count, 0);
`endif
      valid_seen = 1'b0;
      tick(100);
      chk_eq("idle_no_event", valid_seen, 0);

      // 2: digit0=2 with ready low, latency and hold
      set_dig(0, 7'h24);
      sb_q.push_back(ev(0, 2, 0));
      tick(16);
      chk_eq("lat_before_commit", val_out[3:0], 0);
      tick(1);
      chk_eq("lat_commit_val", val_out[3:0], 2);
      chk_eq("lat_commit_ok", digit_ok[0], 1);
      chk_eq("lat_valid_not_yet", evt_valid, 0);
      tick(1);
      chk_eq("lat_valid_rise", {evt_valid, evt_digit, evt_val, evt_err}, {1'b1, 3'd0, 4'd2, 1'b0});
      tick(10);
      chk_eq("hold_stable", {evt_valid, evt_digit, evt_val, evt_err}, {1'b1, 3'd0, 4'd2, 1'b0});
      evt_ready = 1'b1;
      tick(1);
      chk_eq("ack_drop", evt_valid, 0);
      drain("drain_t2");

      // 3: glitch on digit1 (79 for 15 cycles) then 30
      set_dig(1, 7'h79);
      tick(15);
      set_dig(1, 7'h30);
      sb_q.push_back(ev(1, 3, 0));
      tick(20);
      chk_eq("glitch_val", val_out[7:4], 3);
      drain("drain_t3");

      // 4: legal then illegal on digit2; value held
      set_dig(2, 7'h12);
      sb_q.push_back(ev(2, 5, 0));
      tick(20);
      chk_eq("d2_legal_ok", digit_ok[2], 1);
      set_dig(2, 7'h7E);
      sb_q.push_back(ev(2, 5, 1));
      tick(20);
      chk_eq("d2_illegal_ok", digit_ok[2], 0);
      chk_eq("d2_illegal_hold", val_out[11:8], 5);
`ifdef HEXDEC_ERRCNT_EN
      chk_eq("err_count_1", err_count, 1);
`endif
      set_dig(3, 7'h46);
      sb_q.push_back(ev(3, 12, 0));
      tick(20);
      drain("drain_t4");

      // 5: all digits together, spacing 2 cycles; then round robin from next digit
      acc_cyc.delete();
      set_dig(0, 7'h40); set_dig(1, 7'h79); set_dig(2, 7'h24); set_dig(3, 7'h30);
      for (int d = 0; d < ND; d++) sb_q.push_back(ev(d, d, 0));
      tick(30);
      drain("drain_t5a");
      chk_eq("burst_count", acc_cyc.size(), 4);
      for (int k = 1; k < 4; k++) chk_eq("burst_spacing", acc_cyc[k] - acc_cyc[k-1], 2);
      set_dig(0, 7'h19);
      sb_q.push_back(ev(0, 4, 0));
      tick(20);
      set_dig(0, 7'h02); set_dig(1, 7'h78); set_dig(2, 7'h00); set_dig(3, 7'h10);
      sb_q.push_back(ev(1, 7, 0));
      sb_q.push_back(ev(2, 8, 0));
      sb_q.push_back(ev(3, 9, 0));
      sb_q.push_back(ev(0, 6, 0));
      tick(30);
      drain("drain_t5b");

      // coalescing: two commits on digit1 while busy give one event with latest value
      evt_ready = 1'b0;
      set_dig(0, 7'h03);
      sb_q.push_back(ev(0, 11, 0));
      tick(20);
      set_dig(1, 7'h06);
      tick(20);
      set_dig(1, 7'h0E);
      tick(20);
      sb_q.push_back(ev(1, 15, 0));
      evt_ready = 1'b1;
      tick(10);
      drain("drain_coalesce");
      chk_eq("coalesce_val", val_out[7:4], 15);

      // 6: blank digit3 (illegal), then sweep all 16 codes
      set_dig(3, 7'h7F);
      sb_q.push_back(ev(3, 9, 1));
      tick(20);
      for (int v = 0; v < 16; v++) begin
         set_dig(3, seg_tab[v]);
         sb_q.push_back(ev(3, v, 0));
         tick(20);
      end
      drain("drain_sweep");
      chk_eq("sweep_last_val", val_out[15:12], 15);
`ifdef HEXDEC_ERRCNT_EN
      chk_eq("err_count_2", err_count, 2);
`endif

      // reset while presenting
      evt_ready = 1'b0;
      set_dig(2, 7'h40);
      n = 0;
      while (!evt_valid && n < 40) begin
         tick(1);
         n++;
      end
      chk_eq("pre_reset_valid", evt_valid, 1);
      hex_s = {ND{7'h7F}};
      Reset = 1'b1;
      tick(1);
      chk_eq("mid_reset_valid", evt_valid, 0);
      chk_eq("mid_reset_val_out", val_out, 0);
      Reset = 1'b0;
      evt_ready = 1'b1;
      valid_seen = 1'b0;
      tick(40);
      chk_eq("post_reset_no_event", valid_seen, 0);
      chk_eq("sb_final_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
